// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: FSM states, RISC-V funct3 codes and the request bundle.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package corePckg;

    typedef enum logic [1:0] {
        sIdle = 2'd0,
        sReq  = 2'd1,
        sResp = 2'd2,
        sWb   = 2'd3
    } tLsState;

    // Load width/sign codes
    localparam logic [2:0] cLB  = 3'd0;
    localparam logic [2:0] cLH  = 3'd1;
    localparam logic [2:0] cLW  = 3'd2;
    localparam logic [2:0] cLBU = 3'd4;
    localparam logic [2:0] cLHU = 3'd5;

    // Store width codes
    localparam logic [2:0] cSB  = 3'd0;
    localparam logic [2:0] cSH  = 3'd1;
    localparam logic [2:0] cSW  = 3'd2;

    // One execute-stage memory request as captured at the accept edge
    typedef struct packed {
        logic        load;
        logic        store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
    } tLsReq;

endpackage

// File: rtl/load_store_unit_align.sv
// Combinational legality check, store byte-lane steering and load extraction/extension.
// Latency: zero cycles (pure combinational).
// Backpressure: none; LSU_ALIGN_CHECK_EN makes misaligned requests illegal, otherwise low address bits are forced to 0.
module ls_align
    import corePckg::*;
(
    input  tLsReq       iAccReq,
    output logic        oLegal,
    input  tLsReq       iCurReq,
    input  logic [31:0] iRData,
    output logic [3:0]  oWEn,
    output logic [31:0] oWData,
    output logic [31:0] oLdData
);

    logic        codeOk;
    logic [1:0]  curOff;
    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    // Opcode/width legality of the request currently offered by execute
    always_comb begin
        codeOk = 1'b0;
        if (iAccReq.load && !iAccReq.store) begin
            codeOk = iAccReq.funct3 inside {cLB, cLH, cLW, cLBU, cLHU};
        end else if (iAccReq.store && !iAccReq.load) begin
            codeOk = iAccReq.funct3 inside {cSB, cSH, cSW};
        end
    end

`ifdef LSU_ALIGN_CHECK_EN
    // funct3[1:0] encodes the access size: 0 byte, 1 half, 2 word
    assign oLegal = codeOk &&
                    !((iAccReq.funct3[1:0] == 2'd1 && iAccReq.addr[0]) ||
                      (iAccReq.funct3[1:0] == 2'd2 && iAccReq.addr[1:0] != 2'b00));
`else
    assign oLegal = codeOk;
`endif

    // Lane offset with bits below the access size cleared; a no-op for aligned requests
    always_comb begin
        curOff = iCurReq.addr[1:0];
        if (iCurReq.funct3[1:0] == 2'd2) begin
            curOff = 2'b00;
        end else if (iCurReq.funct3[1:0] == 2'd1) begin
            curOff = {iCurReq.addr[1], 1'b0};
        end
    end

    // Store data replication and byte write enables
    always_comb begin
        oWEn   = 4'b0000;
        oWData = 32'd0;
        if (iCurReq.store) begin
            case (iCurReq.funct3)
                cSB: begin
                    oWData = {4{iCurReq.data[7:0]}};
                    oWEn   = 4'b0001 << curOff;
                end
                cSH: begin
                    oWData = {2{iCurReq.data[15:0]}};
                    oWEn   = curOff[1] ? 4'b1100 : 4'b0011;
                end
                cSW: begin
                    oWData = iCurReq.data;
                    oWEn   = 4'b1111;
                end
                default: begin
                    oWData = 32'd0;
                    oWEn   = 4'b0000;
                end
            endcase
        end
    end

    // Pick the addressed lane of the read word and sign/zero-extend it
    always_comb begin
        case (curOff)
            2'd0:    ldByte = iRData[7:0];
            2'd1:    ldByte = iRData[15:8];
            2'd2:    ldByte = iRData[23:16];
            default: ldByte = iRData[31:24];
        endcase
        ldHalf = curOff[1] ? iRData[31:16] : iRData[15:0];
        case (iCurReq.funct3)
            cLB:     oLdData = {{24{ldByte[7]}}, ldByte};
            cLBU:    oLdData = {24'd0, ldByte};
            cLH:     oLdData = {{16{ldHalf[15]}}, ldHalf};
            cLHU:    oLdData = {16'd0, ldHalf};
            default: oLdData = iRData;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: turns execute load/store requests into word accesses and load writebacks.
// Latency: store 2 cycles accept-to-ready, load 4 cycles with writeback pulse 3 cycles after accept.
// Backpressure: oReady low while busy or flushing; LSU_ALIGN_CHECK_EN selects misalignment trapping.
module load_store_unit
    import corePckg::*;
#(
    parameter  int cXLEN     = 32,
    parameter  int cRamDepth = 1024,
    localparam int cAddrW    = $clog2(cRamDepth)
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iValid,
    output logic              oReady,
    input  logic              iLoad,
    input  logic              iStore,
    input  logic [2:0]        iFunct3,
    input  logic [cXLEN-1:0]  iAddr,
    input  logic [cXLEN-1:0]  iStoreData,
    input  logic [4:0]        iRdAddr,
    input  logic              iFlush,
    output logic              oMemEn,
    output logic [3:0]        oMemWEn,
    output logic [cAddrW-1:0] oMemAddr,
    output logic [cXLEN-1:0]  oMemWData,
    input  logic [cXLEN-1:0]  iMemRData,
    output logic              oWbValid,
    output logic [4:0]        oWbRdAddr,
    output logic [cXLEN-1:0]  oWbData,
    output logic              oExcValid,
    output logic [cXLEN-1:0]  oExcAddr
);

    tLsState     state;
    tLsState     nextState;
    tLsReq       accReq;
    tLsReq       reqQ;
    logic        legal;
    logic        accept;
    logic        killWb;
    logic [3:0]  wEn;
    logic [31:0] wData;
    logic [31:0] ldData;

    assign accReq = '{load: iLoad, store: iStore, funct3: iFunct3, addr: iAddr,
                      data: iStoreData, rd: iRdAddr};

    // Ready is also held low during reset so every output reads 0 while it is asserted
    assign oReady    = !iRst && (state == sIdle) && !iFlush;
    assign accept    = iValid && oReady;
    assign oMemAddr  = reqQ.addr[cAddrW+1:2];
    assign oMemWData = wData;
    assign oMemWEn   = (state == sReq) ? wEn : 4'b0000;

    ls_align uAlign (
        .iAccReq (accReq),
        .oLegal  (legal),
        .iCurReq (reqQ),
        .iRData  (iMemRData),
        .oWEn    (wEn),
        .oWData  (wData),
        .oLdData (ldData)
    );

    // FSM state register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= sIdle;
        end else begin
            state <= nextState;
        end
    end

    // Next state plus the memory strobe and writeback pulse
    always_comb begin
        nextState = state;
        oMemEn    = 1'b0;
        oWbValid  = 1'b0;
        case (state)
            sIdle: begin
                if (accept && legal) begin
                    nextState = sReq;
                end
            end
            sReq: begin
                oMemEn    = 1'b1;
                nextState = reqQ.load ? sResp : sIdle;
            end
            sResp: begin
                nextState = sWb;
            end
            sWb: begin
                oWbValid  = !killWb && !iFlush;
                nextState = sIdle;
            end
            default: begin
                nextState = sIdle;
            end
        endcase
    end

    // Request capture, flush tracking, exception pulse and writeback data register
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            reqQ      <= '0;
            killWb    <= 1'b0;
            oExcValid <= 1'b0;
            oExcAddr  <= '0;
            oWbData   <= '0;
            oWbRdAddr <= '0;
        end else begin
            oExcValid <= accept && !legal;
            if (accept) begin
                if (legal) begin
                    reqQ   <= accReq;
                    killWb <= 1'b0;
                end else begin
                    oExcAddr <= iAddr;
                end
            end else if (iFlush && state != sIdle) begin
                // A flushed store still writes; only the load writeback is dropped
                killWb <= 1'b1;
            end
            if (state == sResp && !killWb && !iFlush) begin
                oWbData   <= ldData;
                oWbRdAddr <= reqQ.rd;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
`timescale 1ns/1ps
module tb_load_store_unit;

`ifdef LSU_ALIGN_CHECK_EN
    localparam bit cAlignChk = 1'b1;
`else
    localparam bit cAlignChk = 1'b0;
`endif

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iValid;
    logic        oReady;
    logic        iLoad;
    logic        iStore;
    logic [2:0]  iFunct3;
    logic [31:0] iAddr;
    logic [31:0] iStoreData;
    logic [4:0]  iRdAddr;
    logic        iFlush;
    logic        oMemEn;
    logic [3:0]  oMemWEn;
    logic [9:0]  oMemAddr;
    logic [31:0] oMemWData;
    logic [31:0] iMemRData;
    logic        oWbValid;
    logic [4:0]  oWbRdAddr;
    logic [31:0] oWbData;
    logic        oExcValid;
    logic [31:0] oExcAddr;

    int checks = 0;
    int failures = 0;

    logic [31:0] ram [0:1023];
    logic [7:0]  refBytes [0:4095];

    // Observations collected by runReq
    int          memEnCnt, memEnK, wbCnt, wbK, excCnt, excK, readyK;
    logic [3:0]  obsWEn;
    logic [31:0] obsWData, obsWbData, obsExcAddr;
    logic [9:0]  obsMAddr;
    logic [4:0]  obsRd;

    load_store_unit dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iValid     (iValid),
        .oReady     (oReady),
        .iLoad      (iLoad),
        .iStore     (iStore),
        .iFunct3    (iFunct3),
        .iAddr      (iAddr),
        .iStoreData (iStoreData),
        .iRdAddr    (iRdAddr),
        .iFlush     (iFlush),
        .oMemEn     (oMemEn),
        .oMemWEn    (oMemWEn),
        .oMemAddr   (oMemAddr),
        .oMemWData  (oMemWData),
        .iMemRData  (iMemRData),
        .oWbValid   (oWbValid),
        .oWbRdAddr  (oWbRdAddr),
        .oWbData    (oWbData),
        .oExcValid  (oExcValid),
        .oExcAddr   (oExcAddr)
    );

    always #5 iClk = ~iClk;

    // RAM: byte-lane writes, read data one cycle after the strobe
    always @(posedge iClk) begin
        if (oMemEn) begin
            iMemRData <= ram[oMemAddr];
            for (int l = 0; l < 4; l++) begin
                if (oMemWEn[l]) ram[oMemAddr][8*l +: 8] = oMemWData[8*l +: 8];
            end
        end
    end

    function automatic int accBytes(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit refLegal(input logic ld, input logic st, input logic [2:0] f3,
                                    input logic [31:0] a);
        if (ld == st) return 1'b0;
        if (ld && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b0;
        if (st && f3 >= 3'd3) return 1'b0;
        if (cAlignChk && (int'(a[1:0]) % accBytes(f3)) != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Byte-addressed memory view: value of the sized, extended access
    function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] a);
        int sz = accBytes(f3);
        int base = int'(a[11:0]) & ~(sz - 1);
        logic [31:0] v = 32'd0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = refBytes[base + i];
        if (!f3[2] && sz < 4 && v[8*sz-1]) begin
            for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic refStore(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int sz = accBytes(f3);
        int base = int'(a[11:0]) & ~(sz - 1);
        for (int i = 0; i < sz; i++) refBytes[base + i] = d[8*i +: 8];
    endtask

    task automatic setWord(input int idx, input logic [31:0] v);
        ram[idx] = v;
        for (int j = 0; j < 4; j++) refBytes[4*idx + j] = v[8*j +: 8];
    endtask

    // Offer one request, then watch up to 6 cycles after the accept edge (k=1 is T+1)
    task automatic runReq(input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                          input int flushAt);
        int n = 0;
        memEnCnt = 0; memEnK = 0; wbCnt = 0; wbK = 0; excCnt = 0; excK = 0; readyK = 0;
        obsWEn = 4'd0; obsWData = 32'd0; obsWbData = 32'd0; obsExcAddr = 32'd0;
        obsMAddr = 10'd0; obsRd = 5'd0;
        while (!oReady && n < 20) begin
            @(negedge iClk);
            n++;
        end
        checks++;
        if (oReady !== 1'b1) begin
            failures++;
            $display("FAIL ready_wait: oReady=%b required 1 within 20 cycles", oReady);
            return;
        end
        iValid = 1'b1; iLoad = ld; iStore = st; iFunct3 = f3; iAddr = a;
        iStoreData = d; iRdAddr = rd;
        @(posedge iClk);
        #1;
        iValid = 1'b0; iLoad = 1'b0; iStore = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge iClk);
            if (flushAt != 0 && k == flushAt) iFlush = 1'b1;
            else if (flushAt != 0 && k == flushAt + 1) iFlush = 1'b0;
            #1;
            if (oMemEn) begin
                memEnCnt++; memEnK = k; obsWEn = oMemWEn; obsWData = oMemWData; obsMAddr = oMemAddr;
            end
            if (oWbValid) begin
                wbCnt++; wbK = k; obsWbData = oWbData; obsRd = oWbRdAddr;
            end
            if (oExcValid) begin
                excCnt++; excK = k; obsExcAddr = oExcAddr;
            end
            if (oReady) begin
                readyK = k;
                break;
            end
        end
        iFlush = 1'b0;
    endtask

    task automatic test_reset;
        iRst = 1'b1; iValid = 1'b0; iLoad = 1'b0; iStore = 1'b0; iFunct3 = 3'd0;
        iAddr = 32'd0; iStoreData = 32'd0; iRdAddr = 5'd0; iFlush = 1'b0;
        repeat (2) @(negedge iClk);
        checks++;
        if ({oReady, oMemEn, oMemWEn, oMemAddr, oMemWData, oWbValid, oWbRdAddr, oWbData,
             oExcValid, oExcAddr} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: ready=%b en=%b wen=%h addr=%h wd=%h wbv=%b wbd=%h exc=%b required all 0",
                     oReady, oMemEn, oMemWEn, oMemAddr, oMemWData, oWbValid, oWbData, oExcValid);
        end
        iRst = 1'b0;
        @(negedge iClk);
        checks++;
        if (oReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: oReady=%b required 1", oReady);
        end
    endtask

    task automatic test_stores;
        runReq(1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd0, 0);
        refStore(3'd2, 32'h10, 32'hDEADBEEF);
        checks++;
        if (memEnK !== 1 || obsMAddr !== 10'd4 || obsWEn !== 4'b1111 || obsWData !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL sw_port: k=%0d addr=%h wen=%b wd=%h required k=1 addr=004 wen=1111 wd=deadbeef",
                     memEnK, obsMAddr, obsWEn, obsWData);
        end
        checks++;
        if (readyK !== 2 || wbCnt !== 0) begin
            failures++;
            $display("FAIL sw_ready: readyK=%0d wb=%0d required readyK=2 wb=0", readyK, wbCnt);
        end
        runReq(1'b0, 1'b1, 3'd0, 32'h13, 32'h000000A5, 5'd0, 0);
        refStore(3'd0, 32'h13, 32'h000000A5);
        checks++;
        if (obsWEn !== 4'b1000 || obsWData !== 32'hA5A5A5A5 || obsMAddr !== 10'd4) begin
            failures++;
            $display("FAIL sb_port: wen=%b wd=%h addr=%h required wen=1000 wd=a5a5a5a5 addr=004",
                     obsWEn, obsWData, obsMAddr);
        end
        @(negedge iClk);
        checks++;
        if (ram[4] !== 32'hA5ADBEEF) begin
            failures++;
            $display("FAIL sb_mem: ram[4]=%h required a5adbeef", ram[4]);
        end
    endtask

    task automatic test_loads;
        logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] adrs [4] = '{32'h2, 32'h2, 32'h2, 32'h0};
        logic [31:0] exps [4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF80FF, 32'h00007F01};
        setWord(0, 32'h80FF7F01);
        for (int i = 0; i < 4; i++) begin
            runReq(1'b1, 1'b0, f3s[i], adrs[i], 32'd0, 5'(i + 3), 0);
            checks++;
            if (wbCnt !== 1 || wbK !== 3 || obsWbData !== exps[i] || obsRd !== 5'(i + 3) || readyK !== 4) begin
                failures++;
                $display("FAIL load_ext%0d: wbK=%0d data=%h rd=%0d readyK=%0d required wbK=3 data=%h rd=%0d readyK=4",
                         i, wbK, obsWbData, obsRd, readyK, exps[i], i + 3);
            end
        end
        // Writeback data must persist after the pulse
        @(negedge iClk);
        checks++;
        if (oWbValid !== 1'b0 || oWbData !== 32'h00007F01) begin
            failures++;
            $display("FAIL wb_hold: wbv=%b data=%h required 0 / 00007f01", oWbValid, oWbData);
        end
    endtask

    task automatic test_misaligned;
        setWord(1, 32'h12345678);
        runReq(1'b1, 1'b0, 3'd2, 32'h6, 32'd0, 5'd9, 0);
        checks++;
        if (cAlignChk) begin
            if (excCnt !== 1 || excK !== 1 || obsExcAddr !== 32'h6 || memEnCnt !== 0 || wbCnt !== 0) begin
                failures++;
                $display("FAIL lw_misalign: exc=%0d k=%0d addr=%h memEn=%0d required exc at k=1 addr=6 no access",
                         excCnt, excK, obsExcAddr, memEnCnt);
            end
        end else begin
            if (excCnt !== 0 || obsMAddr !== 10'd1 || wbK !== 3 || obsWbData !== 32'h12345678) begin
                failures++;
                $display("FAIL lw_forced: exc=%0d addr=%h wbK=%0d data=%h required no exc addr=001 wbK=3 12345678",
                         excCnt, obsMAddr, wbK, obsWbData);
            end
        end
        runReq(1'b0, 1'b1, 3'd1, 32'h5, 32'h0000BEEF, 5'd0, 0);
        checks++;
        if (cAlignChk) begin
            if (excCnt !== 1 || obsExcAddr !== 32'h5 || memEnCnt !== 0) begin
                failures++;
                $display("FAIL sh_misalign: exc=%0d addr=%h memEn=%0d required exc addr=5 no access",
                         excCnt, obsExcAddr, memEnCnt);
            end
        end else begin
            refStore(3'd1, 32'h5, 32'h0000BEEF);
            if (excCnt !== 0 || obsWEn !== 4'b0011 || obsWData[15:0] !== 16'hBEEF) begin
                failures++;
                $display("FAIL sh_forced: exc=%0d wen=%b wd=%h required no exc wen=0011 low half beef",
                         excCnt, obsWEn, obsWData);
            end
        end
    endtask

    task automatic test_illegal;
        logic        lds [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        sts [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s [4] = '{3'd2, 3'd2, 3'd3, 3'd3};
        for (int i = 0; i < 4; i++) begin
            runReq(lds[i], sts[i], f3s[i], 32'h40 + 32'(i * 4), 32'd0, 5'd1, 0);
            checks++;
            if (excCnt !== 1 || excK !== 1 || obsExcAddr !== 32'h40 + 32'(i * 4) || memEnCnt !== 0 || readyK !== 1) begin
                failures++;
                $display("FAIL illegal%0d: exc=%0d k=%0d addr=%h memEn=%0d readyK=%0d required exc k=1 addr=%h",
                         i, excCnt, excK, obsExcAddr, memEnCnt, readyK, 32'h40 + 32'(i * 4));
            end
        end
        @(negedge iClk);
        checks++;
        if (oExcValid !== 1'b0) begin
            failures++;
            $display("FAIL exc_pulse: oExcValid=%b required 0 one cycle after the pulse", oExcValid);
        end
    endtask

    task automatic test_flush;
        // Flush in RESP: read completes but no writeback
        runReq(1'b1, 1'b0, 3'd2, 32'h0, 32'd0, 5'd7, 2);
        checks++;
        if (wbCnt !== 0 || readyK !== 4 || memEnCnt !== 1) begin
            failures++;
            $display("FAIL flush_resp: wb=%0d readyK=%0d memEn=%0d required wb=0 readyK=4 memEn=1",
                     wbCnt, readyK, memEnCnt);
        end
        // Flush in REQ on a load
        runReq(1'b1, 1'b0, 3'd2, 32'h0, 32'd0, 5'd7, 1);
        checks++;
        if (wbCnt !== 0 || memEnCnt !== 1 || readyK !== 4) begin
            failures++;
            $display("FAIL flush_req_ld: wb=%0d memEn=%0d readyK=%0d required wb=0 memEn=1 readyK=4",
                     wbCnt, memEnCnt, readyK);
        end
        // Flush in REQ on a store: the write still lands
        runReq(1'b0, 1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 5'd0, 1);
        refStore(3'd2, 32'h20, 32'hCAFEF00D);
        checks++;
        if (memEnCnt !== 1 || obsWEn !== 4'b1111) begin
            failures++;
            $display("FAIL flush_req_st: memEn=%0d wen=%b required 1 / 1111", memEnCnt, obsWEn);
        end
        runReq(1'b1, 1'b0, 3'd2, 32'h20, 32'd0, 5'd8, 0);
        checks++;
        if (obsWbData !== 32'hCAFEF00D || wbCnt !== 1) begin
            failures++;
            $display("FAIL flush_st_read: data=%h wb=%0d required cafef00d 1", obsWbData, wbCnt);
        end
        // Flush in IDLE blocks acceptance
        @(negedge iClk);
        iFlush = 1'b1; iValid = 1'b1; iLoad = 1'b1; iFunct3 = 3'd2; iAddr = 32'h0;
        #1;
        checks++;
        if (oReady !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_ready: oReady=%b required 0", oReady);
        end
        @(negedge iClk);
        checks++;
        if (oMemEn !== 1'b0 || oExcValid !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle_accept: memEn=%b exc=%b required 0 0", oMemEn, oExcValid);
        end
        iValid = 1'b0; iLoad = 1'b0; iFlush = 1'b0;
        repeat (2) @(negedge iClk);
        checks++;
        if (oMemEn !== 1'b0 || oReady !== 1'b1) begin
            failures++;
            $display("FAIL flush_idle_after: memEn=%b ready=%b required 0 1", oMemEn, oReady);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge iClk);
        iValid = 1'b1; iLoad = 1'b1; iStore = 1'b0; iFunct3 = 3'd2; iAddr = 32'h20; iRdAddr = 5'd4;
        @(posedge iClk);
        #1;
        iValid = 1'b0; iLoad = 1'b0;
        repeat (2) @(negedge iClk);
        iRst = 1'b1;
        #1;
        checks++;
        if ({oReady, oMemEn, oMemWEn, oMemAddr, oMemWData, oWbValid, oWbRdAddr, oWbData,
             oExcValid, oExcAddr} !== '0) begin
            failures++;
            $display("FAIL reset_mid: ready=%b en=%b addr=%h wd=%h wbv=%b wbd=%h exc=%b excA=%h required all 0",
                     oReady, oMemEn, oMemAddr, oMemWData, oWbValid, oWbData, oExcValid, oExcAddr);
        end
        @(negedge iClk);
        iRst = 1'b0;
        #1;
        checks++;
        if (oReady !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_ready: oReady=%b required 1", oReady);
        end
        runReq(1'b0, 1'b1, 3'd2, 32'h10, 32'h0BADCAFE, 5'd0, 0);
        refStore(3'd2, 32'h10, 32'h0BADCAFE);
        checks++;
        if (memEnK !== 1 || obsWEn !== 4'b1111 || obsMAddr !== 10'd4 || readyK !== 2 || wbCnt !== 0) begin
            failures++;
            $display("FAIL reset_mid_sw: k=%0d wen=%b addr=%h readyK=%0d wb=%0d required 1 1111 004 2 0",
                     memEnK, obsWEn, obsMAddr, readyK, wbCnt);
        end
    endtask

    task automatic test_back_to_back;
        // Store followed immediately by a load of the same bytes
        runReq(1'b0, 1'b1, 3'd1, 32'h32, 32'h00008123, 5'd0, 0);
        refStore(3'd1, 32'h32, 32'h00008123);
        runReq(1'b1, 1'b0, 3'd1, 32'h32, 32'd0, 5'd11, 0);
        checks++;
        if (obsWbData !== 32'hFFFF8123 || wbK !== 3) begin
            failures++;
            $display("FAIL b2b_lh: data=%h wbK=%0d required ffff8123 3", obsWbData, wbK);
        end
    endtask

    task automatic test_random;
        logic        ld, st;
        logic [2:0]  f3;
        logic [31:0] a, d, expWd, mask;
        logic [3:0]  expWEn;
        logic [4:0]  rd;
        int          kind, sz, off;
        for (int n = 0; n < 200; n++) begin
            kind = $urandom_range(0, 9);
            ld = (kind >= 5) || (kind == 0 && $urandom_range(0, 1) == 1);
            st = (kind >= 1 && kind <= 4) || (kind == 0 && ld);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 4) != 0) begin
                f3 = st ? 3'($urandom_range(0, 2)) : (($urandom_range(0, 1) == 1) ? 3'd4 : 3'd0) + 3'($urandom_range(0, 1));
                if (!st && $urandom_range(0, 2) == 0) f3 = 3'd2;
            end
            a = 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            d = $urandom;
            rd = 5'($urandom_range(0, 31));
            runReq(ld, st, f3, a, d, rd, 0);
            checks++;
            if (!refLegal(ld, st, f3, a)) begin
                if (excCnt !== 1 || excK !== 1 || obsExcAddr !== a || memEnCnt !== 0) begin
                    failures++;
                    $display("FAIL rnd_exc%0d: ld=%b st=%b f3=%0d a=%h exc=%0d excA=%h memEn=%0d required exc at a",
                             n, ld, st, f3, a, excCnt, obsExcAddr, memEnCnt);
                end
            end else if (st) begin
                sz = accBytes(f3);
                off = (int'(a[1:0])) & ~(sz - 1);
                expWEn = 4'(((1 << sz) - 1) << off);
                expWd = 32'd0; mask = 32'd0;
                for (int i = 0; i < sz; i++) begin
                    expWd[8*(off+i) +: 8] = d[8*i +: 8];
                    mask[8*(off+i) +: 8] = 8'hFF;
                end
                if (memEnK !== 1 || readyK !== 2 || obsMAddr !== a[11:2] || obsWEn !== expWEn ||
                    (obsWData & mask) !== expWd || excCnt !== 0) begin
                    failures++;
                    $display("FAIL rnd_st%0d: f3=%0d a=%h k=%0d rk=%0d addr=%h wen=%b wd=%h required wen=%b lanes=%h",
                             n, f3, a, memEnK, readyK, obsMAddr, obsWEn, obsWData, expWEn, expWd);
                end
                refStore(f3, a, d);
            end else begin
                if (wbCnt !== 1 || wbK !== 3 || readyK !== 4 || obsRd !== rd ||
                    obsWbData !== refLoad(f3, a) || excCnt !== 0) begin
                    failures++;
                    $display("FAIL rnd_ld%0d: f3=%0d a=%h wbK=%0d rk=%0d rd=%0d data=%h required data=%h rd=%0d",
                             n, f3, a, wbK, readyK, obsRd, obsWbData, refLoad(f3, a), rd);
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) setWord(i, $urandom);
        test_reset();
        test_stores();
        test_loads();
        test_misaligned();
        test_illegal();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory port: accepts load/store requests from execute and drives word-addressed accesses with byte-lane enables into the data port of the shared instruction/data RAM.
- Steers store data onto byte lanes, then extracts and sign/zero-extends load data for writeback.
- Stalls execute via a ready handshake.
- Sits between execute and writeback, opposite the fetch stage's RAM load/store port.

Parameters:
- cXLEN, 32, datapath width; only 32 is supported.
- cRamDepth, 1024, RAM depth in words; cAddrW = $clog2(cRamDepth).

Ports:
- iClk  in  1  clock
- iRst  in  1  asynchronous reset, active-high
- iValid  in  1  execute request valid
- oReady  out  1  request accepted when iValid && oReady
- iLoad / iStore  in  1 each  operation type
- iFunct3  in  3  RISC-V width/sign code
- iAddr  in  cXLEN  byte address
- iStoreData  in  cXLEN  store operand
- iRdAddr  in  5  load destination register
- iFlush  in  1  pipeline flush
- oMemEn  out  1  memory access strobe
- oMemWEn  out  4  byte write enables
- oMemAddr  out  cAddrW  word address = addr[cAddrW+1:2]
- oMemWData  out  cXLEN  lane-steered store data
- iMemRData  in  cXLEN  read data, valid exactly 1 cycle after oMemEn
- oWbValid  out  1  load result pulse
- oWbRdAddr  out  5  load destination
- oWbData  out  cXLEN  extended load data
- oExcValid  out  1  misaligned/illegal pulse
- oExcAddr  out  cXLEN  faulting address

Behaviour:
- Reset: asynchronous and active-high. All outputs 0, state IDLE; takes effect mid-operation and discards any in-flight access.
- oReady = (state==IDLE) && !iFlush.
- Accepted fields are registered at the accept edge T.
- FSM states: IDLE, REQ, RESP, WB.
  - IDLE→REQ on a legal accept.
  - IDLE→IDLE on an illegal accept, with oExcValid=1 and oExcAddr=iAddr at T+1 for one cycle; no memory access.
  - REQ (T+1): oMemEn=1, oMemAddr and oMemWData valid. Store: oMemWEn nonzero, next state IDLE. Load: oMemWEn=0, next state RESP.
  - RESP (T+2): iMemRData sampled and extracted into the oWbData register; next state WB.
  - WB (T+3): oWbValid=1 with oWbRdAddr; next state IDLE.
- Throughput: a load occupies 4 cycles, a store 2.
- oWbValid, oExcValid and oMemEn are single-cycle pulses; oWbData holds its value between pulses.
- Illegal requests:
  - iLoad && iStore, or neither, while iValid.
  - Load iFunct3 in {3,6,7}.
  - Store iFunct3 >= 3.
  - Misaligned: half with addr[0]=1; word with addr[1:0]!=0.
- Store lanes (b = addr[1:0]):
  - SB: wdata = {4{d[7:0]}}, WEn = 1<<b.
  - SH: wdata = {2{d[15:0]}}, WEn = addr[1] ? 4'b1100 : 4'b0011.
  - SW: WEn = 4'b1111.
- Load extraction:
  - LB/LBU take byte lane b; LH/LHU take half lane addr[1]; LW takes the full word.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Flush:
  - In IDLE: blocks accept.
  - In REQ: a store still completes (write committed); a load completes its read but oWbValid is suppressed.
  - In RESP/WB: oWbValid is suppressed; the FSM still returns to IDLE on schedule.
- iValid while busy is ignored; the requester must hold the request until oReady.

Optional Feature:
- LSU_ALIGN_CHECK_EN defined:
  - Misalignment raises oExcValid as above.
- LSU_ALIGN_CHECK_EN undefined:
  - No misalignment exception.
  - Address low bits below the access size are forced to 0 (half: addr[0]=0; word: addr[1:0]=0) before lane steering.
  - Illegal funct3 and load/store conflicts still raise oExcValid.

Decomposition:
- corePckg holds:
  - tLsState enum.
  - Funct3 constants cLB, cLH, cLW, cLBU, cLHU, cSB, cSH, cSW.
  - tLsReq struct (load, store, funct3, addr, data, rd).
- Sub-module ls_align: purely combinational store steering, load extraction and legality check.
- The FSM and registers stay in load_store_unit.

Test Plan:
- SW addr 0x10, data 0xDEADBEEF → T+1: oMemEn=1, oMemAddr=4, oMemWEn=4'b1111, oMemWData=0xDEADBEEF; oReady back high at T+2.
- SB addr 0x13, data 0x000000A5 → oMemWEn=4'b1000, oMemWData=0xA5A5A5A5.
- Memory word 0x80FF7F01: LB addr 0x2 → oWbData=0xFFFFFFFF at T+3. LBU 0x2 → 0x000000FF. LH 0x2 → 0xFFFF80FF. LHU 0x0 → 0x00007F01.
- LW addr 0x6 with LSU_ALIGN_CHECK_EN → oExcValid=1, oExcAddr=0x6, no oMemEn. Without the macro → reads word 1, oWbValid at T+3.
- Load accepted; iFlush asserted at T+2 → no oWbValid; oReady high at T+4.
- iRst pulsed during RESP → all outputs 0 immediately, oReady=1 after release, the next SW completes normally.
